rs_decode_sequencer: RTL and testbench
======================================

# rs_decode_sequencer

Sequencing controller for the GF(8) RS(7,3) single-symbol-error decoder datapath. It accepts one 21-bit codeword over a valid/ready handshake and runs Horner accumulation of syndromes S1 = r(α) and S2 = r(α²), one symbol per cycle. It then derives error location and value, applies the correction, and presents the corrected codeword, 9-bit message and status until the consumer takes them. It sits between the codeword source and the message sink and replaces the free-running syndrome calculators with a controlled, backpressure-aware pipeline.

## Interface
Parameters:
- CNT_W, default 8: width of the saturating corrected-codeword counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low (asserted at 0); all state cleared immediately.
- clear  in  1  synchronous abort; discards any codeword in flight and returns to IDLE; counter untouched.
- in_valid  in  1  codeword offered.
- in_ready  out  1  high only in IDLE.
- in_codeword  in  21  symbols r6..r0; r6 = [20:18], r0 = [2:0].
- out_valid  out  1  result held valid.
- out_ready  in  1  consumer accepts result.
- out_corrected  out  21  corrected codeword, same layout.
- out_decoded  out  9  message = out_corrected[20:12].
- out_status  out  2  00 no error, 01 corrected, 10 uncorrectable.
- out_err_pos  out  3  corrected symbol index j (0..6); 0 unless status = 01.
- corr_count  out  CNT_W  number of status-01 results handed off; saturates at all-ones.
- busy  out  1  high in any state other than IDLE.

## Operation
- Field: GF(8), p(x) = x³+x+1, polynomial basis. bit0 = coefficient of 1, bit2 = coefficient of α².
- α powers: α⁰ = 001, α¹ = 010, α² = 100, α³ = 011, α⁴ = 110, α⁵ = 111, α⁶ = 101. Addition is XOR. Multiply and divide use log/antilog tables, mod-7 exponent arithmetic, with zero handled explicitly.
- FSM states: IDLE, SYND, LOCATE, OUT.
  - IDLE: in_ready = 1. On in_valid, register the codeword, clear S1/S2 and the symbol counter, then go to SYND.
  - SYND: 7 cycles, counter k = 0..6 processes symbol r(6-k). Each cycle: S1 ← S1·α ⊕ r, S2 ← S2·α² ⊕ r. At k = 6 go to LOCATE. The counter never wraps past 6.
  - LOCATE: 1 cycle. Compute the result and register all outputs, then go to OUT.
    - S1 = S2 = 0: status 00, corrected = input.
    - Exactly one of S1, S2 zero: status 10, corrected = input.
    - Both nonzero: X = S2/S1 = α^j, Y = S1²/S2. Set j = log(X), XOR Y into symbol j, status 01, err_pos = j.
  - OUT: out_valid = 1 with all outputs stable. On out_ready, go to IDLE, and increment corr_count (saturating) if status = 01.
- clear takes priority over every transition, including an OUT handoff; a cleared handoff is not counted.
- reset has priority over clear.

## Timing
- Reset values: in_ready = 1, out_valid = 0, busy = 0. out_corrected, out_decoded, out_status, out_err_pos and corr_count are all 0. State = IDLE.
- Accept edge E0: in_valid & in_ready sampled high.
- E1..E7: syndrome accumulation.
- E8: LOCATE registers the result. out_valid is high from after E8, i.e. 8 cycles after acceptance.
- Handoff edge: out_valid & out_ready. out_valid falls and in_ready rises in the next cycle. No same-cycle output drain and input accept.
- Minimum issue interval: 10 cycles with out_ready held high.
- out_* must not change while out_valid = 1 and out_ready = 0.
- in_codeword is sampled only at E0; later changes are ignored.
- reset asserted mid-SYND or mid-OUT: outputs go to reset values asynchronously, and the result is lost.

## Test plan
- Reset, then in_codeword = 0x000000, out_ready = 1 -> out_valid 8 cycles after accept, status 00, corrected 0x000000, decoded 0x000, corr_count 0.
- 0x000073 (valid word x²+α⁴x+α³) -> status 00, corrected 0x000073, decoded 0x000.
- 0x000600 (error 011 at r3) -> status 01, err_pos 3, corrected 0x000000, corr_count 1.
- 0x140000 (error 101 at r6), out_ready held 0 for 5 cycles -> status 01, err_pos 6, corrected 0x000000, outputs stable while stalled, in_ready 0 throughout, corr_count 2 after handoff.
- 0x00000A (S1 = 0, S2 ≠ 0) -> status 10, corrected 0x00000A, corr_count unchanged.
- clear pulsed during SYND, then reset pulled low during a later SYND -> each returns to IDLE with out_valid never asserted. corr_count unchanged after clear and 0 after reset. The next codeword then decodes correctly.

Source files
------------

// File: rtl/rs_decode_sequencer.sv
// Sequencing controller for the GF(8) RS(7,3) single-symbol-error decoder:
// Horner syndrome accumulation, error locate/correct, and a held result with backpressure.
//
// state  | meaning
// IDLE   | in_ready high, waiting for a codeword
// SYND   | one symbol per cycle into S1 = r(a), S2 = r(a^2), k = 0..6
// LOCATE | derive location/value from S1, S2 and register the result
// OUT    | result held with out_valid until out_ready
module rs_decode_sequencer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [20:0]      in_codeword,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [20:0]      out_corrected,
    output logic [8:0]       out_decoded,
    output logic [1:0]       out_status,
    output logic [2:0]       out_err_pos,
    output logic [CNT_W-1:0] corr_count,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SYND,
        ST_LOCATE,
        ST_OUT
    } state_t;

    localparam logic [1:0] STAT_NONE    = 2'b00;
    localparam logic [1:0] STAT_CORR    = 2'b01;
    localparam logic [1:0] STAT_UNCORR  = 2'b10;

    state_t      state;
    state_t      state_nxt;
    logic [20:0] cw_reg;
    logic [2:0]  s1;
    logic [2:0]  s2;
    logic [2:0]  k_cnt;
    logic [2:0]  sym;
    logic [2:0]  s1_nxt;
    logic [2:0]  s2_nxt;
    logic [2:0]  x_val;
    logic [2:0]  y_val;
    logic [2:0]  j_pos;
    logic [20:0] err_mask;
    logic [1:0]  loc_status;
    logic [2:0]  loc_pos;
    logic [20:0] loc_corr;

    function automatic logic [2:0] gf_exp(input logic [2:0] e);
        logic [2:0] r;
        case (e)
            3'd0:    r = 3'b001;
            3'd1:    r = 3'b010;
            3'd2:    r = 3'b100;
            3'd3:    r = 3'b011;
            3'd4:    r = 3'b110;
            3'd5:    r = 3'b111;
            3'd6:    r = 3'b101;
            default: r = 3'b001;
        endcase
        return r;
    endfunction

    // Log of zero is undefined; callers screen zero operands before use.
    function automatic logic [2:0] gf_log(input logic [2:0] a);
        logic [2:0] r;
        case (a)
            3'b001:  r = 3'd0;
            3'b010:  r = 3'd1;
            3'b100:  r = 3'd2;
            3'b011:  r = 3'd3;
            3'b110:  r = 3'd4;
            3'b111:  r = 3'd5;
            3'b101:  r = 3'd6;
            default: r = 3'd0;
        endcase
        return r;
    endfunction

    function automatic logic [2:0] gf_mul(input logic [2:0] a, input logic [2:0] b);
        logic [3:0] e;
        if (a == 3'b000 || b == 3'b000) begin
            return 3'b000;
        end
        e = {1'b0, gf_log(a)} + {1'b0, gf_log(b)};
        if (e >= 4'd7) begin
            e = e - 4'd7;
        end
        return gf_exp(e[2:0]);
    endfunction

    function automatic logic [2:0] gf_div(input logic [2:0] a, input logic [2:0] b);
        logic [3:0] e;
        if (a == 3'b000 || b == 3'b000) begin
            return 3'b000;
        end
        e = {1'b0, gf_log(a)} + 4'd7 - {1'b0, gf_log(b)};
        if (e >= 4'd7) begin
            e = e - 4'd7;
        end
        return gf_exp(e[2:0]);
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (in_valid) state_nxt = ST_SYND;
            ST_SYND:   if (k_cnt == 3'd6) state_nxt = ST_LOCATE;
            ST_LOCATE: state_nxt = ST_OUT;
            ST_OUT:    if (out_ready) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
        if (clear) begin
            state_nxt = ST_IDLE;
        end
    end

    // Highest-degree symbol first so Horner's rule ends on r0.
    always_comb begin
        sym = 3'b000;
        case (k_cnt)
            3'd0:    sym = cw_reg[20:18];
            3'd1:    sym = cw_reg[17:15];
            3'd2:    sym = cw_reg[14:12];
            3'd3:    sym = cw_reg[11:9];
            3'd4:    sym = cw_reg[8:6];
            3'd5:    sym = cw_reg[5:3];
            3'd6:    sym = cw_reg[2:0];
            default: sym = 3'b000;
        endcase
        s1_nxt = gf_mul(s1, 3'b010) ^ sym;
        s2_nxt = gf_mul(s2, 3'b100) ^ sym;
    end

    // Single error e at position j gives S1 = e*a^j, S2 = e*a^2j.
    always_comb begin
        x_val    = gf_div(s2, s1);
        j_pos    = gf_log(x_val);
        y_val    = gf_div(gf_mul(s1, s1), s2);
        err_mask = '0;
        for (int i = 0; i < 7; i++) begin
            if (j_pos == 3'(i)) begin
                err_mask[3*i +: 3] = y_val;
            end
        end
        loc_status = STAT_NONE;
        loc_pos    = 3'd0;
        loc_corr   = cw_reg;
        if (s1 != 3'b000 && s2 != 3'b000) begin
            loc_status = STAT_CORR;
            loc_pos    = j_pos;
            loc_corr   = cw_reg ^ err_mask;
        end else if (s1 != 3'b000 || s2 != 3'b000) begin
            loc_status = STAT_UNCORR;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cw_reg        <= '0;
            s1            <= '0;
            s2            <= '0;
            k_cnt         <= '0;
            out_corrected <= '0;
            out_status    <= '0;
            out_err_pos   <= '0;
        end else if (!clear) begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        cw_reg <= in_codeword;
                        s1     <= '0;
                        s2     <= '0;
                        k_cnt  <= '0;
                    end
                end
                ST_SYND: begin
                    s1 <= s1_nxt;
                    s2 <= s2_nxt;
                    if (k_cnt != 3'd6) begin
                        k_cnt <= k_cnt + 3'd1;
                    end
                end
                ST_LOCATE: begin
                    out_corrected <= loc_corr;
                    out_status    <= loc_status;
                    out_err_pos   <= loc_pos;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            corr_count <= '0;
        end else if (!clear && state == ST_OUT && out_ready && out_status == STAT_CORR
                     && corr_count != {CNT_W{1'b1}}) begin
            corr_count <= corr_count + CNT_W'(1);
        end
    end

    assign in_ready    = (state == ST_IDLE);
    assign busy        = (state != ST_IDLE);
    assign out_valid   = (state == ST_OUT);
    assign out_decoded = out_corrected[20:12];

endmodule

// File: tb/tb_rs_decode_sequencer.sv
// Testbench for rs_decode_sequencer: fixed vectors, abort/reset sequences, and random
// codewords checked against a polynomial-arithmetic reference model.
module tb_rs_decode_sequencer;

    localparam int CNT_W = 3;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             clk;
    logic             reset;
    logic             clear;
    logic             in_valid;
    logic             in_ready;
    logic [20:0]      in_codeword;
    logic             out_valid;
    logic             out_ready;
    logic [20:0]      out_corrected;
    logic [8:0]       out_decoded;
    logic [1:0]       out_status;
    logic [2:0]       out_err_pos;
    logic [CNT_W-1:0] corr_count;
    logic             busy;

    int n_tests = 0;
    int n_fail  = 0;
    logic [CNT_W-1:0] model_cnt = '0;

    rs_decode_sequencer #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_codeword(in_codeword),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_corrected(out_corrected), .out_decoded(out_decoded),
        .out_status(out_status), .out_err_pos(out_err_pos),
        .corr_count(corr_count), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [20:0] cw;
        int          stall;
        logic [1:0]  st;
        logic [2:0]  pos;
        logic [20:0] corr;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Shift-and-add multiply modulo x^3+x+1.
    function automatic logic [2:0] gmul(input logic [2:0] a, input logic [2:0] b);
        logic [2:0] p = 3'b000;
        logic [2:0] aa = a;
        for (int i = 0; i < 3; i++) begin
            if (b[i]) p ^= aa;
            aa = {aa[1:0], 1'b0} ^ (aa[2] ? 3'b011 : 3'b000);
        end
        return p;
    endfunction

    function automatic logic [2:0] apow(input int n);
        logic [2:0] r = 3'b001;
        for (int i = 0; i < n; i++) r = gmul(r, 3'b010);
        return r;
    endfunction

    function automatic logic [2:0] ginv(input logic [2:0] a);
        for (int b = 1; b < 8; b++) begin
            if (gmul(a, 3'(b)) == 3'b001) return 3'(b);
        end
        return 3'b000;
    endfunction

    task automatic model(input logic [20:0] cw, output logic [1:0] st,
                         output logic [2:0] pos, output logic [20:0] corr);
        logic [2:0] s1 = 3'b000;
        logic [2:0] s2 = 3'b000;
        logic [2:0] x;
        logic [2:0] y;
        for (int i = 0; i < 7; i++) begin
            s1 ^= gmul(cw[3*i +: 3], apow(i));
            s2 ^= gmul(cw[3*i +: 3], apow(2*i));
        end
        st = 2'b00; pos = 3'd0; corr = cw;
        if (s1 != 0 && s2 != 0) begin
            x = gmul(s2, ginv(s1));
            y = gmul(gmul(s1, s1), ginv(s2));
            for (int i = 0; i < 7; i++) if (apow(i) == x) pos = 3'(i);
            corr[3*pos +: 3] ^= y;
            st = 2'b01;
        end else if (s1 != 0 || s2 != 0) begin
            st = 2'b10;
        end
    endtask

    // c(x) = m(x) * (x^2 + a^4 x + a^3), m of degree <= 4.
    function automatic logic [20:0] encode(input logic [14:0] m);
        logic [2:0]  g[3] = '{3'b011, 3'b110, 3'b001};
        logic [20:0] c = '0;
        for (int a = 0; a < 5; a++) begin
            for (int b = 0; b < 3; b++) begin
                c[3*(a+b) +: 3] ^= gmul(m[3*a +: 3], g[b]);
            end
        end
        return c;
    endfunction

    task automatic accept(input logic [20:0] cw);
        int w = 0;
        while (!in_ready && w < 30) begin
            @(negedge clk);
            w++;
        end
        chk("in_ready before accept", {31'd0, in_ready}, 32'd1);
        in_valid    = 1'b1;
        in_codeword = cw;
        @(posedge clk);
        @(negedge clk);
        in_valid    = 1'b0;
        in_codeword = 21'($urandom);
    endtask

    task automatic run_word(input string tag, input logic [20:0] cw, input int stall,
                            input logic [1:0] e_st, input logic [2:0] e_pos,
                            input logic [20:0] e_corr);
        int lat = 0;
        logic [27:0] snap;
        accept(cw);
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, " latency"}, 32'(lat), 32'd8);
        snap = {out_valid, in_ready, out_corrected, out_status, out_err_pos};
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk({tag, " stall hold"},
                {4'd0, out_valid, in_ready, out_corrected, out_status, out_err_pos},
                {4'd0, 1'b1, 1'b0, snap[25:0]});
        end
        chk({tag, " status"}, {30'd0, out_status}, {30'd0, e_st});
        chk({tag, " err_pos"}, {29'd0, out_err_pos}, {29'd0, e_pos});
        chk({tag, " corrected"}, {11'd0, out_corrected}, {11'd0, e_corr});
        chk({tag, " decoded"}, {23'd0, out_decoded}, {23'd0, e_corr[20:12]});
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        if (e_st == 2'b01 && model_cnt != CNT_MAX) model_cnt++;
        chk({tag, " handoff"}, {30'd0, out_valid, in_ready}, {30'd0, 2'b01});
        chk({tag, " corr_count"}, 32'(corr_count), 32'(model_cnt));
    endtask

    initial begin
        vec_t        vecs[5];
        logic [1:0]  m_st;
        logic [2:0]  m_pos;
        logic [20:0] m_corr;
        logic [20:0] c;
        logic [20:0] r;
        logic        seen;
        int          p;
        int          mode;
        int          w;

        vecs[0] = '{21'h000000, 0, 2'b00, 3'd0, 21'h000000};
        vecs[1] = '{21'h000073, 0, 2'b00, 3'd0, 21'h000073};
        vecs[2] = '{21'h000600, 0, 2'b01, 3'd3, 21'h000000};
        vecs[3] = '{21'h140000, 5, 2'b01, 3'd6, 21'h000000};
        vecs[4] = '{21'h00000A, 2, 2'b10, 3'd0, 21'h00000A};

        reset = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_codeword = '0;
        @(negedge clk);
        @(negedge clk);
        chk("reset flags", {29'd0, in_ready, out_valid, busy}, {29'd0, 3'b100});
        chk("reset outputs", {out_corrected, out_status, out_err_pos, corr_count},
            32'd0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            run_word($sformatf("vec%0d", i), vecs[i].cw, vecs[i].stall,
                     vecs[i].st, vecs[i].pos, vecs[i].corr);
        end

        // Abort mid-syndrome: back to IDLE, nothing presented, counter kept.
        accept(21'h000600);
        repeat (3) @(negedge clk);
        chk("clear busy before", {31'd0, busy}, 32'd1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clear idle", {29'd0, in_ready, busy, out_valid}, {29'd0, 3'b100});
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("clear no out_valid", {31'd0, seen}, 32'd0);
        chk("clear corr_count", 32'(corr_count), 32'(model_cnt));

        // Asynchronous reset mid-syndrome.
        accept(21'h140000);
        repeat (4) @(negedge clk);
        reset = 1'b0;
        #1;
        model_cnt = '0;
        chk("midreset flags", {29'd0, in_ready, busy, out_valid}, {29'd0, 3'b100});
        chk("midreset outputs", {out_corrected, out_status, out_err_pos, corr_count},
            32'd0);
        @(negedge clk);
        reset = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("midreset no out_valid", {31'd0, seen}, 32'd0);
        run_word("after reset", 21'h000600, 1, 2'b01, 3'd3, 21'h000000);

        // Clear coinciding with an OUT handoff: dropped and not counted.
        accept(21'h000600);
        w = 0;
        while (!out_valid && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("clr-out reached OUT", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        clear     = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        clear     = 1'b0;
        chk("clr-out idle", {30'd0, out_valid, in_ready}, {30'd0, 2'b01});
        chk("clr-out corr_count", 32'(corr_count), 32'(model_cnt));

        for (int t = 0; t < 40; t++) begin
            mode = $urandom_range(0, 2);
            c = encode(15'($urandom));
            if (mode == 0) begin
                run_word($sformatf("rnd%0d clean", t), c, $urandom_range(0, 3),
                         2'b00, 3'd0, c);
            end else if (mode == 1) begin
                p = $urandom_range(0, 6);
                r = c;
                r[3*p +: 3] ^= 3'($urandom_range(1, 7));
                run_word($sformatf("rnd%0d err", t), r, $urandom_range(0, 3),
                         2'b01, 3'(p), c);
            end else begin
                r = 21'($urandom);
                model(r, m_st, m_pos, m_corr);
                run_word($sformatf("rnd%0d raw", t), r, $urandom_range(0, 3),
                         m_st, m_pos, m_corr);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
